// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_pkg
// Brief    : Shared types, constants and helpers for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE      = 1'b0,
        ARB_WAIT_RESP = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_if
// Brief    : Channel-side and memory-side buses of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
);
    logic [NUM_CHANNELS-1:0]        ch_req_valid;
    logic [NUM_CHANNELS*ADDR_W-1:0] ch_req_address;
    logic [NUM_CHANNELS-1:0]        ch_req_write;
    logic [NUM_CHANNELS*DATA_W-1:0] ch_req_write_data;
    logic [NUM_CHANNELS-1:0]        ch_req_ready;
    logic [NUM_CHANNELS-1:0]        ch_resp_valid;
    logic [NUM_CHANNELS-1:0]        ch_resp_error;
    logic [DATA_W-1:0]              ch_resp_read_data;
    logic [NUM_CHANNELS-1:0]        ch_resp_ready;

    logic                           mem_req_valid;
    logic [ADDR_W-1:0]              mem_req_address;
    logic                           mem_req_write;
    logic [DATA_W-1:0]              mem_req_write_data;
    logic                           mem_req_ready;
    logic                           mem_resp_valid;
    logic                           mem_resp_error;
    logic [DATA_W-1:0]              mem_resp_read_data;
    logic                           mem_resp_ready;

    // The arbiter side
    modport master (
        input  ch_req_valid, ch_req_address, ch_req_write, ch_req_write_data, ch_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_error, mem_resp_read_data,
        output ch_req_ready, ch_resp_valid, ch_resp_error, ch_resp_read_data,
        output mem_req_valid, mem_req_address, mem_req_write, mem_req_write_data, mem_resp_ready
    );

    // The requesters plus memory controller side
    modport slave (
        output ch_req_valid, ch_req_address, ch_req_write, ch_req_write_data, ch_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_error, mem_resp_read_data,
        input  ch_req_ready, ch_resp_valid, ch_resp_error, ch_resp_read_data,
        input  mem_req_valid, mem_req_address, mem_req_write, mem_req_write_data, mem_resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter_round_robin_pointer.sv
`default_nettype none
// ============================================================================
// Module   : round_robin_pointer
// Brief    : Round-robin channel pointer with advance and load-after-owner.
// Revision : 1.0 - initial release
// ============================================================================
module round_robin_pointer
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int IDX_W        = $clog2(NUM_CHANNELS)
) (
    input  wire logic             clock,
    input  wire logic             clear_n,
    input  wire logic             advance,
    input  wire logic             load,
    input  wire logic [IDX_W-1:0] load_base,
    output logic      [IDX_W-1:0] ptr
);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= IDX_W'(wrap_inc(32'(load_base), NUM_CHANNELS));
        end else if (advance) begin
            ptr <= IDX_W'(wrap_inc(32'(ptr), NUM_CHANNELS));
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Round-robin, one-in-flight arbiter of N requesters onto one
//            memory port. MEMORY_ARBITER_TIMEOUT_EN adds a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS   = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int IDX_W          = $clog2(NUM_CHANNELS)
) (
    input  wire logic             clock,
    input  wire logic             clear_n,
    memory_arbiter_if.master      bus,
    output logic                  busy,
    output logic      [IDX_W-1:0] owner
);

    arb_state_t              state, state_d;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic                    advance, load, timed_out;
    logic [NUM_CHANNELS-1:0] req_ready, resp_valid, resp_error;
    logic                    req_valid, resp_ready;
    logic [ADDR_W-1:0]       sel_address;
    logic                    sel_write, sel_valid;
    logic [DATA_W-1:0]       sel_write_data;

    round_robin_pointer #(.NUM_CHANNELS(NUM_CHANNELS), .IDX_W(IDX_W)) u_ptr (
        .clock     (clock),
        .clear_n   (clear_n),
        .advance   (advance),
        .load      (load),
        .load_base (owner_q),
        .ptr       (ptr)
    );

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer;

    // Timer sits at zero in IDLE, so it starts from zero on every WAIT_RESP entry
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)                timer <= '0;
        else if (state == ARB_IDLE)  timer <= '0;
        else if (!timed_out)         timer <= timer + 1'b1;
    end
    assign timed_out = (state == ARB_WAIT_RESP) && (timer >= TIMER_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        sel_valid      = 1'b0;
        sel_address    = '0;
        sel_write      = 1'b0;
        sel_write_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (IDX_W'(i) == ptr) begin
                sel_valid      = bus.ch_req_valid[i];
                sel_address    = bus.ch_req_address[i*ADDR_W +: ADDR_W];
                sel_write      = bus.ch_req_write[i];
                sel_write_data = bus.ch_req_write_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state;
        owner_d    = owner_q;
        advance    = 1'b0;
        load       = 1'b0;
        req_ready  = '0;
        req_valid  = 1'b0;
        resp_valid = '0;
        resp_error = '0;
        resp_ready = 1'b1;
        case (state)
            ARB_IDLE: begin
                // Ready is a function of the pointer only, never of any request valid
                req_ready[ptr] = bus.mem_req_ready;
                req_valid      = sel_valid & bus.mem_req_ready;
                if (req_valid) begin
                    state_d = ARB_WAIT_RESP;
                    owner_d = ptr;
                end else begin
                    advance = 1'b1;
                end
            end
            ARB_WAIT_RESP: begin
                if (timed_out) begin
                    resp_valid[owner_q] = 1'b1;
                    resp_error[owner_q] = 1'b1;
                    resp_ready          = 1'b0;
                    if (bus.ch_resp_ready[owner_q]) begin
                        state_d = ARB_IDLE;
                        load    = 1'b1;
                    end
                end else begin
                    resp_valid[owner_q] = bus.mem_resp_valid;
                    resp_error[owner_q] = bus.mem_resp_error;
                    resp_ready          = bus.ch_resp_ready[owner_q];
                    if (bus.mem_resp_valid && bus.ch_resp_ready[owner_q]) begin
                        state_d = ARB_IDLE;
                        load    = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state   <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            state   <= state_d;
            owner_q <= owner_d;
        end
    end

    assign busy  = (state == ARB_WAIT_RESP);
    assign owner = owner_q;

    assign bus.ch_req_ready       = req_ready;
    assign bus.ch_resp_valid      = resp_valid;
    assign bus.ch_resp_error      = resp_error;
    assign bus.ch_resp_read_data  = bus.mem_resp_read_data;
    assign bus.mem_req_valid      = req_valid;
    assign bus.mem_req_address    = sel_address;
    assign bus.mem_req_write      = sel_write;
    assign bus.mem_req_write_data = sel_write_data;
    assign bus.mem_resp_ready     = resp_ready;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Directed self-checking bench for memory_arbiter (2 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic       clock;
    logic       clear_n;
    logic       busy;
    logic [0:0] owner;
    int         checks = 0;
    int         passes = 0;

    memory_arbiter_if #(.NUM_CHANNELS(2), .ADDR_W(32), .DATA_W(32)) bus ();

    memory_arbiter #(
        .NUM_CHANNELS   (2),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus),
        .busy    (busy),
        .owner   (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.ch_req_valid       = 2'b00;
        bus.ch_req_address     = {32'h0000_2000, 32'h0000_1000};
        bus.ch_req_write       = 2'b00;
        bus.ch_req_write_data  = {32'hBBBB_0001, 32'hAAAA_0000};
        bus.ch_resp_ready      = 2'b11;
        bus.mem_req_ready      = 1'b1;
        bus.mem_resp_valid     = 1'b0;
        bus.mem_resp_error     = 1'b0;
        bus.mem_resp_read_data = 32'h0;
        clear_n                = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_req_ready", bus.ch_req_ready, 2'b01);
        check("rst_resp_valid", bus.ch_resp_valid, 2'b00);
        check("rst_mem_resp_ready", bus.mem_resp_ready, 1);
        clear_n = 1'b1;

        // Single request from ch0, response three cycles after issue
        bus.ch_req_valid = 2'b01;
        #1;
        check("single_mem_valid", bus.mem_req_valid, 1);
        check("single_mem_addr", bus.mem_req_address, 32'h0000_1000);
        tick();
        bus.ch_req_valid = 2'b00;
        #1;
        check("single_busy", busy, 1);
        check("single_req_ready_wait", bus.ch_req_ready, 2'b00);
        check("single_no_resp_c1", bus.ch_resp_valid, 2'b00);
        tick(); tick();
        bus.mem_resp_valid     = 1'b1;
        bus.mem_resp_read_data = 32'hDEAD_BEEF;
        #1;
        check("single_resp_valid", bus.ch_resp_valid, 2'b01);
        check("single_resp_data", bus.ch_resp_read_data, 32'hDEAD_BEEF);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("single_idle", busy, 0);
        check("single_ptr_after", bus.ch_req_ready, 2'b10);

        // Idle rotation brings the pointer back to ch0
        tick();
        check("rotate_ptr0", bus.ch_req_ready, 2'b01);

        // Fairness: both channels hold valid continuously
        bus.ch_req_valid = 2'b11;
        for (int t = 0; t < 6; t++) begin
            #1;
            check("fair_grant_ready", bus.ch_req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
            check("fair_addr", bus.mem_req_address, (t % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            tick();
            check("fair_owner", owner, t % 2);
            bus.mem_resp_valid     = 1'b1;
            bus.mem_resp_read_data = 32'(t);
            #1;
            check("fair_resp_route", bus.ch_resp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            bus.mem_resp_valid = 1'b0;
        end
        bus.ch_req_valid = 2'b00;

        // Back-pressure: pointer keeps rotating, ready stays low
        bus.mem_req_ready = 1'b0;
        bus.ch_req_valid  = 2'b10;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("bp_req_ready", bus.ch_req_ready, 2'b00);
            check("bp_mem_valid", bus.mem_req_valid, 0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        #1;
        check("bp_ptr0_no_grant", bus.mem_req_valid, 0);
        tick();
        check("bp_ch1_ready", bus.ch_req_ready, 2'b10);
        check("bp_ch1_addr", bus.mem_req_address, 32'h0000_2000);
        tick();
        bus.ch_req_valid = 2'b00;
        #1;
        check("bp_owner", owner, 1);

        // Response stall on the owner channel
        bus.ch_resp_ready      = 2'b00;
        bus.mem_resp_valid     = 1'b1;
        bus.mem_resp_read_data = 32'h0000_0055;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_mem_resp_ready", bus.mem_resp_ready, 0);
            check("stall_busy", busy, 1);
            tick();
        end
        bus.ch_resp_ready = 2'b11;
        #1;
        check("stall_release", bus.mem_resp_ready, 1);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("stall_done", busy, 0);

        // Stray response in IDLE is drained
        bus.mem_resp_valid = 1'b1;
        #1;
        check("stray_resp_valid", bus.ch_resp_valid, 2'b00);
        check("stray_mem_resp_ready", bus.mem_resp_ready, 1);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("stray_stays_idle", busy, 0);

        // Reset during WAIT_RESP; late response drained
        bus.ch_req_valid = 2'b10;
        #1;
        check("rstmid_grant", bus.ch_req_ready, 2'b10);
        tick();
        bus.ch_req_valid = 2'b00;
        check("rstmid_owner_pre", owner, 1);
        clear_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_owner", owner, 0);
        check("rstmid_ptr", bus.ch_req_ready, 2'b01);
        clear_n = 1'b1;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("rstmid_late_drop", bus.ch_resp_valid, 2'b00);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("rstmid_idle", busy, 0);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
        // Watchdog: synthesized error response eight cycles after issue
        bus.ch_req_valid = 2'b10;
        #1;
        check("to_grant", bus.mem_req_valid, 1);
        tick();
        bus.ch_req_valid = 2'b00;
        for (int k = 1; k < 8; k++) begin
            check("to_quiet", bus.ch_resp_valid, 2'b00);
            tick();
        end
        check("to_resp_valid", bus.ch_resp_valid, 2'b10);
        check("to_resp_error", bus.ch_resp_error, 2'b10);
        check("to_mem_resp_ready", bus.mem_resp_ready, 0);
        tick(); tick(); tick(); tick();
        bus.mem_resp_valid = 1'b1;
        #1;
        check("to_late_drop", bus.ch_resp_valid, 2'b00);
        check("to_idle", busy, 0);
        bus.mem_resp_valid = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single hart-to-memory-controller port between `NUM_CHANNELS` requesters (instruction fetch, load/store, debug). Requests are forwarded combinationally to the memory controller. Each response is routed back to the channel that issued the matching request. Exactly one transaction is in flight at a time. Grant order is round-robin and readiness-first: a channel sees `ready` before it raises `valid`, so fetch-style requesters that drive `valid = ready & want` never form a combinational loop.

## Interface
- `NUM_CHANNELS`, 2, number of requesters (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, read/write data width
- `TIMEOUT_CYCLES`, 255, watchdog limit (used only with the timeout macro)

- `clock`  in  1  single clock, rising edge
- `clear_n`  in  1  asynchronous, active-low reset
- `ch_req_valid`  in  NUM_CHANNELS  per-channel request valid
- `ch_req_address`  in  NUM_CHANNELS*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- `ch_req_write`  in  NUM_CHANNELS  1 = store
- `ch_req_write_data`  in  NUM_CHANNELS*DATA_W  store data
- `ch_req_ready`  out  NUM_CHANNELS  per-channel accept
- `ch_resp_valid`  out  NUM_CHANNELS  response valid, owner channel only
- `ch_resp_error`  out  NUM_CHANNELS  response error, owner channel only
- `ch_resp_read_data`  out  DATA_W  broadcast to all channels; qualified by `ch_resp_valid`
- `ch_resp_ready`  in  NUM_CHANNELS  per-channel response accept
- `mem_req_valid`, `mem_req_address`, `mem_req_write`, `mem_req_write_data`  out  1/ADDR_W/1/DATA_W  to memory controller
- `mem_req_ready`  in  1
- `mem_resp_valid`, `mem_resp_error`, `mem_resp_read_data`  in  1/1/DATA_W  from memory controller
- `mem_resp_ready`  out  1
- `busy`  out  1  registered; high in WAIT_RESP
- `owner`  out  $clog2(NUM_CHANNELS)  registered; channel of in-flight transaction

## Operation
- **Registers:**
  - `state` ∈ {IDLE, WAIT_RESP}
  - `ptr`: round-robin pointer
  - `owner_q`
  - `timer` (timeout builds only)
- **IDLE:**
  - `ch_req_ready[i] = (i == ptr) & mem_req_ready`. All other channels see ready = 0.
  - The `mem_req_*` fields are muxed from channel `ptr`.
  - `mem_req_valid = ch_req_valid[ptr] & mem_req_ready`.
  - Handshake fires when `ch_req_valid[ptr] & mem_req_ready`. Next state is WAIT_RESP with `owner_q <= ptr`.
  - If the handshake does not fire, `ptr <= ptr+1` (wrapping at `NUM_CHANNELS-1 -> 0`). This applies whether the pointed channel is idle or the memory controller is not ready.
  - `mem_resp_ready = 1`. A response arriving in IDLE is stray and is drained; no channel sees it.
- **WAIT_RESP:**
  - All `ch_req_ready = 0`.
  - `ch_resp_valid[owner_q] = mem_resp_valid` and `ch_resp_error[owner_q] = mem_resp_error`. All other bits are 0.
  - `mem_resp_ready = ch_resp_ready[owner_q]`.
  - When `mem_resp_valid & ch_resp_ready[owner_q]`, next state is IDLE with `ptr <= owner_q+1` (wrapping).
- `ch_req_ready` must never depend on any `ch_req_valid`. This is a hard rule.
- `ch_resp_read_data = mem_resp_read_data` at all times.

## Timing
- Request path is zero latency (combinational pass-through); response path is zero latency.
- Minimum spacing between transactions is 2 cycles: issue in IDLE, response earliest one cycle later. Issue and response in the same cycle cannot occur; a response in that cycle is treated as stray.
- Idle-channel rotation costs 1 cycle per skipped channel. Worst-case grant wait is NUM_CHANNELS−1 cycles plus the current transaction.
- **Reset (`clear_n` low, async):**
  - State: `state = IDLE`, `ptr = 0`, `owner_q = 0`, `timer = 0`.
  - Outputs: `busy = 0`, `owner = 0`.
  - Combinational outputs follow from IDLE: `ch_req_ready[0] = mem_req_ready`, all response valids 0, `mem_resp_ready = 1`.
- Reset mid-transaction: the in-flight transaction is abandoned, and its late response is drained as stray.

## Configuration
- **`MEMORY_ARBITER_TIMEOUT_EN` defined:**
  - `timer` clears on entry to WAIT_RESP and increments each WAIT_RESP cycle.
  - On reaching `TIMEOUT_CYCLES` with no response, the arbiter presents a synthesized response: `ch_resp_valid[owner_q] = 1`, `ch_resp_error[owner_q] = 1`, `mem_resp_ready = 0`.
  - The arbiter holds that response until `ch_resp_ready[owner_q]`, then returns to IDLE.
  - A later real response is drained as stray.
- **Undefined:** there is no timer, and WAIT_RESP waits indefinitely.

## Structure
- Package `memory_arbiter_pkg`: state enum (`ARB_IDLE`, `ARB_WAIT_RESP`) and the default `TIMEOUT_CYCLES` constant.
- Sub-module `round_robin_pointer`: holds `ptr` and supports advance, load `owner+1`, and wrap at `NUM_CHANNELS`.

## Test plan
- **Single request:** ch0 requests a read of 0x0000_1000 with mem always ready; response 0xDEAD_BEEF arrives 3 cycles later.
  - Cycle 0: `mem_req_valid = 1`, address 0x1000.
  - `ch_resp_valid[0] = 1` with data 0xDEAD_BEEF.
  - ch1 sees no response.
- **Fairness under contention:** ch0 and ch1 both hold valid continuously for 6 transactions → grant order 0,1,0,1,0,1 and `owner` toggles.
- **Back-pressure:** `mem_req_ready = 0` for 4 cycles while ch1 is valid → `ptr` rotates each cycle and `ch_req_ready` is never high. ch1 is granted only on the first cycle with `mem_req_ready` high and `ptr = 1`.
- **Response stall and stray response:**
  - `ch_resp_ready[0] = 0` for 3 cycles → `mem_resp_ready = 0` and the state stays WAIT_RESP.
  - A stray `mem_resp_valid` in IDLE → drained, all `ch_resp_valid = 0`.
- **Timeout (macro on, `TIMEOUT_CYCLES = 8`):** memory never responds → at cycle 8 after issue, `ch_resp_valid[owner] = 1` with error 1; a response at cycle 12 is drained.
- **Reset mid-operation:** `clear_n` low during WAIT_RESP → immediately `busy = 0`, `owner = 0`, `ptr = 0`, and the late response is drained.
